// File: rtl/led_frame_sequencer.sv
// Double-buffered WS2812 frame store and scheduler with valid/ready pixel output.
// Optional LED_BRIGHTNESS_EN scales each colour channel by a per-frame brightness.
module led_frame_sequencer #(
    parameter int LED_NUM        = 7,
    parameter int IDX_W          = 3,
    parameter int REFRESH_CYCLES = 240000,
    parameter int LATCH_CYCLES   = 780
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [23:0]      wr_data,
    input  logic             commit,
    input  logic             start,
    input  logic             auto_en,
    input  logic [7:0]       bright,
    output logic [23:0]      pix_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             pix_last,
    output logic             busy,
    output logic             frame_done
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TW    = $clog2(REFRESH_CYCLES + 1);
    localparam int LW    = $clog2(LATCH_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST     = IDX_W'(LED_NUM - 1);
    localparam logic [TW-1:0]    T_RELOAD = TW'(REFRESH_CYCLES - 1);
    localparam logic [LW-1:0]    L_END    = LW'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        LATCH
    } state_t;

    state_t state, state_n;

    logic [23:0]      mem [2][DEPTH];
    logic             disp_bank;
    logic             disp_n;
    logic             commit_pend;
    logic             start_pend;
    logic [TW-1:0]    timer;
    logic [LW-1:0]    lcnt, lcnt_n;
    logic [IDX_W-1:0] idx, idx_n, idx_inc;
    logic             tick, trig, beat, swap, wr_hit, last_idx;
    logic [23:0]      load_px, next_px;

    logic [23:0]      pix_data_n;
    logic             pix_valid_n, pix_last_n, busy_n, frame_done_n;

    assign tick     = auto_en && (timer == '0);
    assign trig     = start || tick;
    assign beat     = pix_valid && pix_ready;
    assign swap     = (state == LOAD) && commit_pend;
    assign wr_hit   = wr_en && (32'(wr_addr) < LED_NUM);
    assign last_idx = (idx == LAST);
    assign idx_inc  = idx + 1'b1;
    assign disp_n   = swap ? ~disp_bank : disp_bank;

`ifdef LED_BRIGHTNESS_EN
    logic [7:0] bright_q;

    function automatic logic [23:0] scale(input logic [23:0] c,
                                          input logic [7:0]  b);
        logic [16:0] p;
        logic [23:0] r;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            p = c[k*8 +: 8] * ({1'b0, b} + 9'd1);
            r[k*8 +: 8] = 8'(p >> 8);
        end
        return r;
    endfunction

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            bright_q <= '0;
        else if (state == LOAD)
            bright_q <= bright;
    end

    // LOAD uses the live input; the rest of the frame uses the latched copy
    assign load_px = scale(mem[disp_n][0], bright);
    assign next_px = scale(mem[disp_bank][idx_inc], bright_q);
`else
    logic unused_bright;
    assign unused_bright = ^bright;
    assign load_px       = mem[disp_n][0];
    assign next_px       = mem[disp_bank][idx_inc];
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            timer <= T_RELOAD;
        else if (!auto_en || timer == '0)
            timer <= T_RELOAD;
        else
            timer <= timer - 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            commit_pend <= 1'b0;
            start_pend  <= 1'b0;
            disp_bank   <= 1'b0;
        end else begin
            if (commit)
                commit_pend <= 1'b1;
            else if (state == LOAD)
                commit_pend <= 1'b0;
            if (state == IDLE)
                start_pend <= 1'b0;
            else if (trig)
                start_pend <= 1'b1;
            if (swap)
                disp_bank <= ~disp_bank;
        end
    end

    // On swap the old display bank becomes the back bank, refilled from the new display bank
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < DEPTH; i++)
                    mem[b][i] <= '0;
        end else begin
            if (swap)
                for (int i = 0; i < LED_NUM; i++)
                    mem[disp_bank][i] <= mem[~disp_bank][i];
            if (wr_hit)
                mem[~disp_n][wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (trig || start_pend) state_n = LOAD;
            LOAD:    state_n = STREAM;
            STREAM:  if (beat && last_idx) state_n = LATCH;
            LATCH:   if (lcnt == L_END) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        pix_data_n   = pix_data;
        pix_valid_n  = pix_valid;
        pix_last_n   = pix_last;
        idx_n        = idx;
        lcnt_n       = lcnt;
        frame_done_n = 1'b0;
        busy_n       = (state_n != IDLE);
        unique case (state)
            LOAD: begin
                idx_n       = '0;
                pix_valid_n = 1'b1;
                pix_data_n  = load_px;
                pix_last_n  = (LAST == '0);
            end
            STREAM: begin
                if (beat && last_idx) begin
                    pix_valid_n = 1'b0;
                    pix_last_n  = 1'b0;
                    pix_data_n  = '0;
                    lcnt_n      = '0;
                end else if (beat) begin
                    idx_n      = idx_inc;
                    pix_data_n = next_px;
                    pix_last_n = (idx_inc == LAST);
                end
            end
            LATCH: begin
                lcnt_n       = lcnt + 1'b1;
                frame_done_n = (lcnt == L_END);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            pix_last   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            idx        <= '0;
            lcnt       <= '0;
        end else begin
            pix_data   <= pix_data_n;
            pix_valid  <= pix_valid_n;
            pix_last   <= pix_last_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
            idx        <= idx_n;
            lcnt       <= lcnt_n;
        end
    end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Bench for led_frame_sequencer: directed steps with random data and stalls,
// checked against a bank-level colour model.
module tb_led_frame_sequencer;

    localparam int N   = 7;
    localparam int IW  = 3;
    localparam int REF = 1000;
    localparam int LAT = 780;
`ifdef LED_BRIGHTNESS_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_addr = '0;
    logic [23:0]   wr_data = '0;
    logic          commit = 1'b0;
    logic          start = 1'b0;
    logic          auto_en = 1'b0;
    logic [7:0]    bright = 8'hFF;
    logic [23:0]   pix_data;
    logic          pix_valid;
    logic          pix_ready = 1'b0;
    logic          pix_last;
    logic          busy;
    logic          frame_done;

    always #5 CLK = ~CLK;

    led_frame_sequencer #(
        .LED_NUM(N), .IDX_W(IW),
        .REFRESH_CYCLES(REF), .LATCH_CYCLES(LAT)
    ) dut (
        .CLK(CLK), .RST(RST),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .start(start), .auto_en(auto_en),
        .bright(bright),
        .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_last(pix_last),
        .busy(busy), .frame_done(frame_done)
    );

    int checks = 0;
    int errors = 0;
    logic [23:0] front [N];
    logic [23:0] back  [N];
    logic [23:0] fexp  [N];
    bit commit_flag = 1'b0;
    int inject = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] mscale(input logic [23:0] c,
                                           input logic [7:0] b);
        int r, ch;
        if (!BR) return c;
        r = 0;
        for (int k = 0; k < 3; k++) begin
            ch = int'((c >> (8 * k)) & 24'hFF);
            r += ((ch * (int'(b) + 1)) / 256) << (8 * k);
        end
        return 24'(r);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            front[i] = '0;
            back[i]  = '0;
        end
        commit_flag = 1'b0;
    endtask

    task automatic begin_frame();
        if (commit_flag) begin
            front = back;
            commit_flag = 1'b0;
        end
        for (int i = 0; i < N; i++)
            fexp[i] = mscale(front[i], bright);
    endtask

    task automatic wr(input int a, input logic [23:0] d);
        @(negedge CLK);
        wr_en = 1'b1;
        wr_addr = IW'(a);
        wr_data = d;
        if (a < N) back[a] = d;
        @(negedge CLK);
        wr_en = 1'b0;
    endtask

    task automatic do_commit();
        @(negedge CLK);
        commit = 1'b1;
        commit_flag = 1'b1;
        @(negedge CLK);
        commit = 1'b0;
    endtask

    task automatic do_start(input string tag);
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        begin_frame();
        chk({tag, "_load_busy"}, busy, 1);
        chk({tag, "_load_valid"}, pix_valid, 0);
    endtask

    task automatic stream(input string tag, input int stall_pct,
                          input int stall_at, output int t);
        int k, sc;
        bit stalled, rdy;
        logic [23:0] held;
        logic held_last;
        k = 0; sc = 0; t = 0; stalled = 0; held = '0; held_last = 0;
        while (k < N && t < 3000) begin
            @(negedge CLK);
            t++;
            if (inject == 1 && t == 3) begin
                commit = 1'b1; commit_flag = 1'b1;
                wr_en = 1'b1; wr_addr = IW'(7); wr_data = 24'h123456;
            end
            if (inject == 1 && t == 4) begin
                commit = 1'b0; wr_en = 1'b0;
            end
            if (inject == 2 && t == 2) bright = 8'h10;
            if (stalled) begin
                chk({tag, "_hold_valid"}, pix_valid, 1);
                chk({tag, "_hold_data"}, pix_data, held);
                chk({tag, "_hold_last"}, pix_last, held_last);
            end
            if (pix_valid) begin
                if (k == stall_at && sc < 5) begin
                    rdy = 0; sc++;
                end else begin
                    rdy = ($urandom_range(99) >= stall_pct);
                end
                pix_ready = rdy;
                if (rdy) begin
                    chk($sformatf("%s_px%0d", tag, k), pix_data, fexp[k]);
                    chk($sformatf("%s_last%0d", tag, k), pix_last, (k == N - 1));
                    k++;
                    stalled = 0;
                end else begin
                    held = pix_data;
                    held_last = pix_last;
                    stalled = 1;
                end
            end
        end
        chk({tag, "_beats"}, k, N);
    endtask

    task automatic latch_wait(input string tag, input int offset);
        int g;
        g = offset;
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            pix_ready = 1'b0;
            if (frame_done) break;
            g++;
        end
        chk({tag, "_gap"}, g, LAT);
        chk({tag, "_done_busy"}, busy, 0);
        @(negedge CLK);
        chk({tag, "_done_pulse"}, frame_done, 0);
    endtask

    initial begin
        int t;
        int rises[$];
        bit pv;
        model_reset();

        repeat (3) @(negedge CLK);
        chk("rst_valid", pix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", pix_data, 0);
        chk("rst_done", frame_done, 0);
        RST = 1'b1;

        // basic frame with identity brightness
        for (int i = 0; i < N; i++) wr(i, 24'h110000 + 24'(i));
        do_commit();
        do_start("t1");
        stream("t1", 0, -1, t);
        chk("t1_cycles", t, N);
        latch_wait("t1", 0);

        // random colours, random stalls and a 5-cycle stall mid-frame
        for (int i = 0; i < N; i++) wr(i, 24'($urandom));
        do_commit();
        do_start("t2");
        stream("t2", 30, 3, t);
        latch_wait("t2", 0);

        // uncommitted write, commit mid-frame, out-of-range write
        wr(2, 24'hABCDEF);
        do_start("t3a");
        inject = 1;
        stream("t3a", 20, -1, t);
        inject = 0;
        latch_wait("t3a", 0);
        do_start("t3b");
        stream("t3b", 0, -1, t);
        latch_wait("t3b", 0);

        // auto refresh period
        pix_ready = 1'b1;
        @(negedge CLK);
        auto_en = 1'b1;
        pv = 0;
        for (int i = 1; i <= 3020; i++) begin
            @(negedge CLK);
            pix_ready = 1'b1;
            if (pix_valid && !pv) rises.push_back(i);
            pv = pix_valid;
            if (i == 3005) auto_en = 1'b0;
        end
        for (int i = 0; i < 2000 && busy; i++) @(negedge CLK);
        chk("t4_frames", rises.size(), 3);
        chk("t4_first", rises.size() > 0 ? rises[0] : -1, REF + 1);
        chk("t4_period1", rises.size() > 1 ? rises[1] - rises[0] : -1, REF);
        chk("t4_period2", rises.size() > 2 ? rises[2] - rises[1] : -1, REF);
        chk("t4_idle", busy, 0);
        pix_ready = 1'b0;
        repeat (3) @(negedge CLK);

        // two starts while busy queue exactly one extra frame
        do_start("t4x");
        stream("t4x", 0, -1, t);
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        latch_wait("t4x", 4);
        chk("t4y_load_busy", busy, 1);
        chk("t4y_load_valid", pix_valid, 0);
        begin_frame();
        stream("t4y", 0, -1, t);
        latch_wait("t4y", 0);
        repeat (50) @(negedge CLK);
        chk("t4_no_third", busy, 0);

        // asynchronous reset mid-stream
        do_start("t5");
        pix_ready = 1'b1;
        repeat (3) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("t5_async_valid", pix_valid, 0);
        chk("t5_async_busy", busy, 0);
        pix_ready = 1'b0;
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("t5_post_valid", pix_valid, 0);
        do_start("t5b");
        stream("t5b", 20, -1, t);
        latch_wait("t5b", 0);

        // brightness latched per frame
        wr(0, 24'hFF8040);
        do_commit();
        bright = 8'h7F;
        do_start("t6a");
        stream("t6a", 0, -1, t);
        latch_wait("t6a", 0);
        bright = 8'hFF;
        do_start("t6b");
        inject = 2;
        stream("t6b", 10, -1, t);
        inject = 0;
        latch_wait("t6b", 0);
        do_start("t6c");
        stream("t6c", 0, -1, t);
        latch_wait("t6c", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
